// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg: shared constants and types for the restoring divider.
//   - default operand width and the matching iteration-counter width
//   - FSM state encoding (IDLE / WORK / DZ)
// Optional build macro used by the divider: DIVIDER_DIVZERO_EN.
// ----------------------------------------------------------------------------
package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH_DEFAULT = 8;

  // Width of the iteration counter for a given operand width.
  // A 1-bit floor keeps the counter legal for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Counter width at the default operand width.
  localparam int DIV_CNT_W_DEFAULT = cnt_width(DIV_WIDTH_DEFAULT);

  // FSM states. DZ is only reachable when divide-by-zero detection is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DZ   = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step: one combinational restoring-division step.
//   - shifts the dividend MSB into the partial remainder
//   - trial-subtracts the divisor
//   - keeps the difference when non-negative (quotient bit 1),
//     otherwise restores the shifted remainder (quotient bit 0)
//   - shifts the new quotient bit into the LSB of the dividend register,
//     so after WIDTH steps that register holds the quotient
// ----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_in,        // partial remainder, WIDTH+1 bits
  input  logic [WIDTH-1:0] dividend_in,   // dividend bits still to consume (+ quotient bits)
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] dividend_out,
  output logic             q_bit
);

  // One extra bit on top of the remainder so the subtraction sign is visible.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  // Shift-in, trial subtract and select for a single quotient bit.
  // NOTE: every output of a combinational block is assigned on every path
  // (here via a default first) so no latch is inferred.
  always_comb begin
    rem_out      = '0;
    dividend_out = '0;
    q_bit        = 1'b0;

    w_shift = {rem_in, dividend_in[WIDTH-1]};
    w_diff  = w_shift - {2'b00, divisor_in};
    w_neg   = w_diff[WIDTH+1];

    q_bit        = ~w_neg;
    rem_out      = w_neg ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    dividend_out = {dividend_in[WIDTH-2:0], q_bit};
  end

endmodule : div_step

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider: unsigned restoring divider, one quotient bit per clock, MSB first.
//   q_out = a_in / b_in, r_out = a_in % b_in, both registered and held until
//   the next completion. busy_o is high for exactly WIDTH cycles per division.
//
// Build option:
//   DIVIDER_DIVZERO_EN  defined   -> b_in = 0 at start takes a one-cycle DZ
//                                    path: q_out = all ones, r_out = a_in,
//                                    err_o = 1.
//                       undefined -> no DZ state, err_o tied low; b_in = 0
//                                    runs the normal algorithm, which yields
//                                    the same q_out/r_out.
//
// Reset is synchronous, active-high, and clears every register including the
// working datapath, so an aborted division leaves no trace.
// ----------------------------------------------------------------------------
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_dividend;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem;        // partial remainder, one guard bit
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;

  // --------------------------------------------------------------------------
  // Control decoded by the FSM
  // --------------------------------------------------------------------------
  state_t w_state_next;
  logic   w_load;      // capture operands and start a new operation
  logic   w_step;      // perform one restoring step this cycle
  logic   w_finish;    // last WORK step: publish quotient/remainder
`ifdef DIVIDER_DIVZERO_EN
  logic   w_dz_done;   // DZ cycle: publish divide-by-zero result
  logic   r_err;
`endif

  // --------------------------------------------------------------------------
  // Single restoring step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_dividend_next;
  logic             w_q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in       (r_rem),
    .dividend_in  (r_dividend),
    .divisor_in   (r_divisor),
    .rem_out      (w_rem_next),
    .dividend_out (w_dividend_next),
    .q_bit        (w_q_bit)
  );

  // The quotient bit is already folded into w_dividend_next; keep it named
  // for waveform readability.
  logic w_q_bit_unused;
  assign w_q_bit_unused = w_q_bit;

  // Next-state and control decode; defaults first, then per-state overrides.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
`ifdef DIVIDER_DIVZERO_EN
    w_dz_done    = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
`ifdef DIVIDER_DIVZERO_EN
          w_state_next = (b_in == '0) ? ST_DZ : ST_WORK;
`else
          w_state_next = ST_WORK;
`endif
        end
      end

      ST_WORK: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

`ifdef DIVIDER_DIVZERO_EN
      ST_DZ: begin
        w_dz_done    = 1'b1;
        w_state_next = ST_IDLE;
      end
`endif

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register and datapath update; synchronous reset clears everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the working registers are reset too, not just the outputs, so an
    // operation aborted by reset cannot leak stale operands into the next one.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q_out    <= '0;
      r_r_out    <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_load) begin
        r_dividend <= a_in;
        r_divisor  <= b_in;
        r_rem      <= '0;
        r_cnt      <= '0;
      end else if (w_step) begin
        r_dividend <= w_dividend_next;
        r_rem      <= w_rem_next;
        r_cnt      <= r_cnt + CNT_W'(1);
      end

      if (w_finish) begin
        r_q_out <= w_dividend_next;
        r_r_out <= w_rem_next[WIDTH-1:0];
      end
`ifdef DIVIDER_DIVZERO_EN
      else if (w_dz_done) begin
        r_q_out <= '1;
        r_r_out <= r_dividend;
      end
`endif
    end
  end

`ifdef DIVIDER_DIVZERO_EN
  // Divide-by-zero flag: set by the DZ cycle, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_load) begin
      r_err <= 1'b0;
    end else if (w_dz_done) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // Any non-IDLE state is an operation in progress; derived from a register.
  assign busy_o = (r_state != ST_IDLE);
  assign q_out  = r_q_out;
  assign r_out  = r_r_out;

endmodule : divider

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high (sampled on rising clk edge only).
REQ-004 start  input  1  request a division; sampled only while IDLE.
REQ-005 a_in  input  WIDTH  dividend, unsigned.
REQ-006 b_in  input  WIDTH  divisor, unsigned.
REQ-007 q_out  output  WIDTH  quotient, registered.
REQ-008 r_out  output  WIDTH  remainder, registered.
REQ-009 busy_o  output  1  high while a division is in progress.
REQ-010 err_o  output  1  divide-by-zero flag, registered (see Configuration).

Function
REQ-011 The block SHALL compute unsigned restoring division: q_out = a_in / b_in and r_out = a_in % b_in, at one quotient bit per cycle, MSB first.
REQ-012 The FSM SHALL have the states IDLE, WORK and DZ, encoded as package constants.
REQ-013 In IDLE with start=1, the block SHALL capture a_in/b_in, clear the partial remainder and the iteration counter, set busy_o=1 and go to WORK; otherwise it SHALL hold.
REQ-014 Each WORK cycle SHALL shift the dividend MSB into the partial remainder (WIDTH+1 bits) and trial-subtract the divisor; if the result is non-negative, it SHALL keep the difference and set the quotient bit to 1, else restore and set the bit to 0.
REQ-015 On the WORK cycle with counter = WIDTH-1, the block SHALL register the final q_out/r_out, set busy_o=0 and return to IDLE; busy_o SHALL be high exactly WIDTH cycles (8 at default).
REQ-016 start asserted while busy_o=1 SHALL be ignored; a_in/b_in changes after capture SHALL NOT affect the result.
REQ-017 q_out/r_out SHALL hold the last result until the next completion and SHALL NOT be cleared at start.
REQ-018 Back-to-back: start sampled on the first IDLE cycle after completion SHALL be accepted (one idle cycle minimum between operations).
REQ-019 err_o SHALL clear when a new start is accepted.

Reset
REQ-020 rst=1 SHALL force state=IDLE, q_out=0, r_out=0, busy_o=0, err_o=0, counter=0 and the working registers=0, including mid-operation; the aborted result SHALL be discarded.
REQ-021 rst SHALL take priority over start in the same cycle.

Configuration
REQ-022 Macro DIVIDER_DIVZERO_EN defined: b_in=0 at start SHALL go to DZ for one cycle (busy_o=1), then write q_out=all-ones, r_out=a_in, err_o=1 and return to IDLE; total busy is 1 cycle.
REQ-023 Macro undefined: DZ SHALL be absent, err_o SHALL be tied to 0, and b_in=0 SHALL run the normal WIDTH-cycle algorithm, which naturally yields q_out=all-ones and r_out=a_in.

Structure
REQ-024 A shared package div_pkg SHALL hold the state constants (IDLE/WORK/DZ), the default WIDTH, and the counter width ($clog2 of WIDTH).
REQ-025 A combinational sub-module div_step SHALL implement one restoring step (shift-in, trial subtract, select, quotient bit); divider SHALL instantiate it once and hold the FSM and registers.

Verification
REQ-026 100/7 -> busy_o high 8 cycles, then q_out=14, r_out=2, err_o=0.
REQ-027 255/1 -> q_out=255, r_out=0; 5/9 -> q_out=0, r_out=5; 12/12 -> q_out=1, r_out=0.
REQ-028 0/0 and 37/0 with DIVIDER_DIVZERO_EN -> busy_o high 1 cycle, q_out=255, r_out=0 and 37 respectively, err_o=1; without the macro -> busy 8 cycles, same q/r, err_o=0.
REQ-029 Start 200/3; pulse start with 9/9 on cycle 3 of busy -> the second start is ignored, result q_out=66, r_out=2.
REQ-030 Start 200/3; assert rst on cycle 4 -> next cycle q_out=0, r_out=0, busy_o=0; then 50/4 -> q_out=12, r_out=2.
REQ-031 Exhaustive sweep a,b in 0..12 against a reference model, with the start pulse width and wait-for-!busy_o handshake matching the team multiplier bench.
